signed_mult_mac: RTL and testbench
==================================

// Module: signed_mult_mac
// PURPOSE
//  Parametrised multi-channel signed multiplier / multiply-accumulator with a valid/ready stream
//  interface and a configurable pipeline depth. CH independent lanes share one handshake.
//  Each beat is either a plain product (acc=0) or a product added to a per-lane running sum (acc=1).
//  Sits between the sample source and the downstream filter/DSP stages; replaces fixed 8x8 multipliers.
// PARAMETERS
//  DIN_W   8   signed operand width per lane
//  CH      2   number of lanes
//  PIPE    2   pipeline registers from input to dout; legal range >=1
//  ACC_W   20  accumulator width per lane; must be >=2*DIN_W
//  OUT_W   16  output width per lane; must be <=ACC_W
// PORTS
//  clk       in   1         clock, rising edge
//  rst_n     in   1         synchronous reset, active low
//  din_a     in   CH*DIN_W  lane k operand A at [k*DIN_W +: DIN_W], signed
//  din_b     in   CH*DIN_W  lane k operand B, same packing
//  din_acc   in   1         1 = accumulate this beat; 0 = plain product
//  din_last  in   1         clear all accumulators after this beat (meaningful only with din_acc=1)
//  din_vld   in   1         input beat valid
//  din_rdy   out  1         block accepts a beat this cycle
//  dout      out  CH*OUT_W  lane k result at [k*OUT_W +: OUT_W], signed
//  dout_vld  out  1         output beat valid
//  dout_rdy  in   1         downstream accepts a beat
// BEHAVIOUR
//  - Reset: while rst_n=0 at clk edge, dout=0, dout_vld=0, all pipe valids=0, all accumulators=0.
//    din_rdy=0 during reset; from the first cycle after reset, din_rdy=1.
//  - Global enable en = !dout_vld | dout_rdy. din_rdy = en. Transfer in: din_vld&din_rdy.
//    Transfer out: dout_vld&dout_rdy. When en=0, every pipeline stage and dout hold their value.
//  - Latency: exactly PIPE cycles from the input transfer to dout_vld when never stalled.
//    Throughput is 1 beat/cycle. Bubbles (din_vld=0) propagate as invalid stages.
//  - Arithmetic: p = $signed(a)*$signed(b), full 2*DIN_W bits, sign-extended to ACC_W.
//    acc=0: r = p, and the accumulator is untouched.
//    acc=1: r = acc_reg + p, wrapping modulo 2^ACC_W. acc_reg <= last ? 0 : r.
//  - The accumulator updates only when the beat leaves the last internal stage with en=1.
//    Stalled beats never double-count. Invalid stages never touch the accumulator.
//  - Output narrowing from ACC_W to OUT_W: see CONFIGURATION. With OUT_W=ACC_W it is a pass-through.
//  - din_last with acc=0 has no effect. acc=0 and acc=1 beats may interleave freely; the sum persists.
//  - Reset mid-accumulation discards the in-flight beats and the partial sums. The next acc beat
//    starts from 0.
// CONFIGURATION
//  Macro SIGNED_MULT_MAC_SAT_EN:
//    Defined: r is clamped to [-2^(OUT_W-1), 2^(OUT_W-1)-1] before it drives dout.
//      The accumulator itself is never clamped.
//    Undefined: dout = r[OUT_W-1:0] (two's-complement truncation). There is no saturation logic.
// STRUCTURE
//  Package signed_mult_pkg holds:
//    - Width legality checks, as localparam/elaboration asserts.
//    - The function sat_narrow(ACC_W->OUT_W) used under the macro.
//  Sub-module signed_mult_lane, instantiated CH times via generate. Each lane contains:
//    - a PIPE-1 deep product pipe;
//    - the acc register;
//    - the narrow logic.
//  The top owns the valid pipe, the acc/last side-band pipe, en and din_rdy. The lanes receive en.
// TESTING (DIN_W=8, CH=2, PIPE=2, ACC_W=20, OUT_W=16, dout_rdy=1 unless stated)
//  1 Corners: (a,b) = lane0 (-128,-128), lane1 (127,-128), acc=0
//    -> 2 cycles later dout lanes = 16384, -16256; dout_vld high 1 cycle.
//  2 Accumulate: three beats of lane0 127*127, acc=1, last on the 3rd
//    -> dout 16129, 32258, then 32767 with the macro or -17149 without it.
//    A following acc beat of 1*1 -> 1.
//  3 Backpressure: 10 back-to-back beats (a=i, b=2), dout_rdy=0 for cycles 3..7
//    -> din_rdy=0 while dout_vld&!dout_rdy; dout stable; all 10 results (2i) appear in order.
//  4 Mixed: acc=1 5*5, then acc=0 3*3, then acc=1 2*2 -> 25, 9, 29.
//  5 Reset mid-op: rst_n=0 for 1 cycle after 2 acc beats of 10*10 are in flight
//    -> dout_vld=0, dout=0; the next acc beat 4*4 -> 16.
//  6 Bubbles: din_vld toggling 1,0,1,0 -> dout_vld pattern 1,0,1,0 delayed 2 cycles.

Source files
------------

// File: rtl/signed_mult_pkg.sv
// Shared definitions for the signed multiplier / MAC.
//   widths_ok  : elaboration-time legality check of the width parameters.
//   sat_narrow : clamps a sign-extended accumulator value to the signed range of out_w bits.
//                Used only when SIGNED_MULT_MAC_SAT_EN is defined.
package signed_mult_pkg;

  // Widest accumulator the saturating narrower can handle.
  localparam int unsigned MaxAccW = 64;

  function automatic bit widths_ok(input int unsigned din_w, input int unsigned ch,
                                   input int unsigned pipe, input int unsigned acc_w,
                                   input int unsigned out_w);
    return (din_w >= 1) && (ch >= 1) && (pipe >= 1) && (acc_w >= 2 * din_w) &&
           (out_w >= 2) && (out_w <= acc_w) && (acc_w <= MaxAccW);
  endfunction

  function automatic logic signed [MaxAccW-1:0] sat_narrow(input logic signed [MaxAccW-1:0] r,
                                                           input int unsigned out_w);
    logic signed [MaxAccW-1:0] hi;
    logic signed [MaxAccW-1:0] lo;
    hi = (64'sd1 <<< (out_w - 1)) - 64'sd1;
    lo = -hi - 64'sd1;
    if (r > hi) return hi;
    if (r < lo) return lo;
    return r;
  endfunction

endpackage

// File: rtl/signed_mult_mac_if.sv
// Valid/ready stream bundle for signed_mult_mac.
//   din_a/din_b : CH packed signed operands, lane k at [k*DIN_W +: DIN_W]
//   din_acc     : accumulate this beat; din_last: clear accumulators after this beat
//   din_vld/rdy : input handshake
//   dout        : CH packed signed results, lane k at [k*OUT_W +: OUT_W]
//   dout_vld/rdy: output handshake
// master = beat source / result sink, slave = the multiplier block.
interface signed_mult_mac_if #(
  parameter int unsigned DIN_W = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned OUT_W = 16
) ();
  logic [CH*DIN_W-1:0] din_a;
  logic [CH*DIN_W-1:0] din_b;
  logic                din_acc;
  logic                din_last;
  logic                din_vld;
  logic                din_rdy;
  logic [CH*OUT_W-1:0] dout;
  logic                dout_vld;
  logic                dout_rdy;

  modport master (
    output din_a, din_b, din_acc, din_last, din_vld, dout_rdy,
    input  din_rdy, dout, dout_vld
  );

  modport slave (
    input  din_a, din_b, din_acc, din_last, din_vld, dout_rdy,
    output din_rdy, dout, dout_vld
  );
endinterface

// File: rtl/signed_mult_lane.sv
// One lane of signed_mult_mac: product pipe (PIPE-1 deep), per-lane accumulator and the
// ACC_W -> OUT_W narrowing feeding the registered output.
//   clk, rst_n : clock, synchronous active-low reset
//   en         : global pipeline advance
//   a, b       : signed operands
//   fire       : a valid beat leaves the last product stage this cycle (already gated by en)
//   acc, last  : side-band of that beat
//   dout       : registered narrowed result
// Macro SIGNED_MULT_MAC_SAT_EN selects saturation instead of truncation on the output.
module signed_mult_lane
  import signed_mult_pkg::*;
#(
  parameter int unsigned DIN_W = 8,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 16
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    en,
  input  logic signed [DIN_W-1:0] a,
  input  logic signed [DIN_W-1:0] b,
  input  logic                    fire,
  input  logic                    acc,
  input  logic                    last,
  output logic signed [OUT_W-1:0] dout
);

  logic signed [2*DIN_W-1:0] prod;
  logic signed [ACC_W-1:0]   prod_ext;
  logic signed [ACC_W-1:0]   stage_p;
  logic signed [ACC_W-1:0]   acc_q;
  logic signed [ACC_W-1:0]   sum;
  logic signed [OUT_W-1:0]   narrow;
  logic signed [OUT_W-1:0]   dout_q;

  assign prod     = a * b;
  assign prod_ext = ACC_W'(prod);

  if (PIPE > 1) begin : g_pipe
    logic signed [ACC_W-1:0] pp_q [PIPE-1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE - 1; i++) pp_q[i] <= '0;
      end else if (en) begin
        pp_q[0] <= prod_ext;
        for (int i = 1; i < PIPE - 1; i++) pp_q[i] <= pp_q[i-1];
      end
    end
    assign stage_p = pp_q[PIPE-2];
  end else begin : g_nopipe
    assign stage_p = prod_ext;
  end

  // Wraps modulo 2^ACC_W by construction.
  assign sum = acc ? acc_q + stage_p : stage_p;

  // Only a beat that actually leaves the stage touches the sum, so stalls never double-count.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      acc_q <= '0;
    end else if (fire && acc) begin
      acc_q <= last ? '0 : sum;
    end
  end

`ifdef SIGNED_MULT_MAC_SAT_EN
  assign narrow = OUT_W'(sat_narrow(MaxAccW'(sum), OUT_W));
`else
  assign narrow = OUT_W'(sum);
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_q <= '0;
    end else if (en) begin
      dout_q <= narrow;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/signed_mult_mac.sv
// Multi-channel signed multiplier / multiply-accumulator with a valid/ready stream.
// CH lanes share one handshake; latency is PIPE cycles, throughput one beat per cycle.
//   clk   : clock, rising edge
//   rst_n : synchronous reset, active low
//   bus   : signed_mult_mac_if slave (operands, acc/last side-band, handshakes, results)
// Macro SIGNED_MULT_MAC_SAT_EN: saturate results to OUT_W instead of truncating.
module signed_mult_mac
  import signed_mult_pkg::*;
#(
  parameter int unsigned DIN_W = 8,
  parameter int unsigned CH    = 2,
  parameter int unsigned PIPE  = 2,
  parameter int unsigned ACC_W = 20,
  parameter int unsigned OUT_W = 16
) (
  input logic              clk,
  input logic              rst_n,
  signed_mult_mac_if.slave bus
);

  if (!widths_ok(DIN_W, CH, PIPE, ACC_W, OUT_W)) begin : g_bad_params
    $error("signed_mult_mac: illegal width parameters");
  end

  logic en;
  logic in_fire;
  logic stage_vld;
  logic stage_acc;
  logic stage_last;
  logic fire;
  logic dout_vld_q;

  // The whole pipe advances together; it only stops when a result is stuck at the output.
  assign en          = !dout_vld_q || bus.dout_rdy;
  assign bus.din_rdy = rst_n && en;
  assign in_fire     = bus.din_vld && bus.din_rdy;

  if (PIPE > 1) begin : g_pipe
    logic vld_q  [PIPE-1];
    logic acc_q  [PIPE-1];
    logic last_q [PIPE-1];
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        for (int i = 0; i < PIPE - 1; i++) begin
          vld_q[i]  <= 1'b0;
          acc_q[i]  <= 1'b0;
          last_q[i] <= 1'b0;
        end
      end else if (en) begin
        vld_q[0]  <= in_fire;
        acc_q[0]  <= bus.din_acc;
        last_q[0] <= bus.din_last;
        for (int i = 1; i < PIPE - 1; i++) begin
          vld_q[i]  <= vld_q[i-1];
          acc_q[i]  <= acc_q[i-1];
          last_q[i] <= last_q[i-1];
        end
      end
    end
    assign stage_vld  = vld_q[PIPE-2];
    assign stage_acc  = acc_q[PIPE-2];
    assign stage_last = last_q[PIPE-2];
  end else begin : g_nopipe
    assign stage_vld  = in_fire;
    assign stage_acc  = bus.din_acc;
    assign stage_last = bus.din_last;
  end

  assign fire = stage_vld && en;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      dout_vld_q <= 1'b0;
    end else if (en) begin
      dout_vld_q <= stage_vld;
    end
  end

  assign bus.dout_vld = dout_vld_q;

  for (genvar k = 0; k < CH; k++) begin : g_lane
    logic signed [OUT_W-1:0] lane_dout;
    signed_mult_lane #(
      .DIN_W (DIN_W),
      .PIPE  (PIPE),
      .ACC_W (ACC_W),
      .OUT_W (OUT_W)
    ) u_lane (
      .clk   (clk),
      .rst_n (rst_n),
      .en    (en),
      .a     (bus.din_a[k*DIN_W +: DIN_W]),
      .b     (bus.din_b[k*DIN_W +: DIN_W]),
      .fire  (fire),
      .acc   (stage_acc),
      .last  (stage_last),
      .dout  (lane_dout)
    );
    assign bus.dout[k*OUT_W +: OUT_W] = lane_dout;
  end

endmodule

// File: tb/tb_signed_mult_mac.sv
// Directed bench for signed_mult_mac (DIN_W=8, CH=2, PIPE=2, ACC_W=20, OUT_W=16).
// Expected results come from a small lane model and travel through a scoreboard queue.
module tb_signed_mult_mac;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;

  typedef struct {
    logic [31:0] data;
    int          cyc;
    bit          chk;
  } exp_t;

  exp_t             q[$];
  logic signed [19:0] macc [2];
  logic             hist [0:4095];
  logic             stall_prev = 1'b0;
  logic [31:0]      dout_prev = '0;

  signed_mult_mac_if #(.DIN_W(8), .CH(2), .OUT_W(16)) bus ();

  signed_mult_mac #(
    .DIN_W (8),
    .CH    (2),
    .PIPE  (2),
    .ACC_W (20),
    .OUT_W (16)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [15:0] narrow16(input logic signed [19:0] r);
`ifdef SIGNED_MULT_MAC_SAT_EN
    if (r > 20'sd32767) return 16'h7fff;
    if (r < -20'sd32768) return 16'h8000;
`endif
    return r[15:0];
  endfunction

  task automatic push(input int a0, input int b0, input int a1, input int b1,
                      input bit acc, input bit last, input bit chk);
    int a [2];
    int b [2];
    logic signed [19:0] p;
    logic signed [19:0] r;
    exp_t e;
    a[0] = a0; b[0] = b0; a[1] = a1; b[1] = b1;
    for (int k = 0; k < 2; k++) begin
      p = 20'(a[k] * b[k]);
      r = acc ? macc[k] + p : p;
      if (acc) macc[k] = last ? 20'sd0 : r;
      e.data[k*16 +: 16] = narrow16(r);
    end
    e.cyc = cyc;
    e.chk = chk;
    q.push_back(e);
  endtask

  task automatic drive(input int a0, input int b0, input int a1, input int b1,
                       input bit acc, input bit last, input bit vld);
    bus.din_a    = {8'(a1), 8'(a0)};
    bus.din_b    = {8'(b1), 8'(b0)};
    bus.din_acc  = acc;
    bus.din_last = last;
    bus.din_vld  = vld;
  endtask

  // Called #1 after a rising edge; returns #1 after the edge that took the beat.
  task automatic send(input int a0, input int b0, input int a1, input int b1,
                      input bit acc, input bit last, input bit chk);
    int n;
    drive(a0, b0, a1, b1, acc, last, 1'b1);
    n = 0;
    @(negedge clk);
    while (!bus.din_rdy && n < 50) begin
      @(negedge clk);
      n++;
    end
    check("send_rdy", bus.din_rdy, 1);
    if (bus.din_rdy) push(a0, b0, a1, b1, acc, last, chk);
    @(posedge clk);
    #1;
    bus.din_vld = 1'b0;
  endtask

  task automatic do_reset(input int n);
    rst_n       = 1'b0;
    bus.din_vld = 1'b0;
    q.delete();
    macc[0] = '0;
    macc[1] = '0;
    repeat (n) @(posedge clk);
    @(negedge clk);
    check("reset_dout_vld", bus.dout_vld, 0);
    check("reset_dout", bus.dout, 0);
    check("reset_din_rdy", bus.din_rdy, 0);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    @(negedge clk);
    check("post_reset_din_rdy", bus.din_rdy, 1);
    @(posedge clk);
    #1;
  endtask

  task automatic drain();
    int n;
    n = 0;
    while (q.size() != 0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    check("drain_empty", q.size(), 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin
    exp_t e;
    hist[cyc] <= bus.dout_vld;
    if (rst_n) begin
      if (bus.dout_vld && !bus.dout_rdy) check("stall_din_rdy", bus.din_rdy, 0);
      if (stall_prev) begin
        check("stall_hold_vld", bus.dout_vld, 1);
        check("stall_hold_dout", bus.dout, dout_prev);
      end
      if (bus.dout_vld && bus.dout_rdy) begin
        if (q.size() == 0) begin
          check("unexpected_out", bus.dout_vld, 0);
        end else begin
          e = q.pop_front();
          check("dout", bus.dout, e.data);
          if (e.chk) check("latency", cyc - e.cyc, 2);
        end
      end
      stall_prev <= bus.dout_vld && !bus.dout_rdy;
      dout_prev  <= bus.dout;
    end else begin
      stall_prev <= 1'b0;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    bit pat [4];
    int c0;
    pat = '{1'b1, 1'b0, 1'b1, 1'b0};
    bus.dout_rdy = 1'b1;
    drive(0, 0, 0, 0, 1'b0, 1'b0, 1'b0);
    do_reset(3);

    // Corner products
    send(-128, -128, 127, -128, 1'b0, 1'b0, 1'b1);
    drain();

    // Accumulate three beats, clear on the third, then restart from zero
    send(127, 127, -100, 50, 1'b1, 1'b0, 1'b1);
    send(127, 127, -100, 50, 1'b1, 1'b0, 1'b1);
    send(127, 127, -100, 50, 1'b1, 1'b1, 1'b1);
    send(1, 1, -1, 1, 1'b1, 1'b1, 1'b1);
    drain();

    // Back-to-back beats with downstream backpressure
    fork
      begin
        for (int i = 1; i <= 10; i++) send(i, 2, -i, 2, 1'b0, 1'b0, 1'b0);
      end
      begin
        repeat (3) @(posedge clk);
        #1;
        bus.dout_rdy = 1'b0;
        repeat (5) @(posedge clk);
        #1;
        bus.dout_rdy = 1'b1;
      end
    join
    drain();

    // Mixed accumulate / plain beats
    send(5, 5, -5, 5, 1'b1, 1'b0, 1'b1);
    send(3, 3, -3, 3, 1'b0, 1'b1, 1'b1);
    send(2, 2, -2, 2, 1'b1, 1'b1, 1'b1);
    drain();

    // Reset with accumulate beats in flight
    send(10, 10, -10, 10, 1'b1, 1'b0, 1'b1);
    send(10, 10, -10, 10, 1'b1, 1'b0, 1'b1);
    do_reset(1);
    send(4, 4, -4, 4, 1'b1, 1'b1, 1'b1);
    drain();

    // Bubbles
    c0 = cyc;
    for (int i = 0; i < 4; i++) begin
      drive(3 + i, 3, -3 - i, 3, 1'b0, 1'b0, pat[i]);
      if (pat[i]) push(3 + i, 3, -3 - i, 3, 1'b0, 1'b0, 1'b1);
      @(posedge clk);
      #1;
    end
    bus.din_vld = 1'b0;
    drain();
    for (int i = 0; i < 4; i++) check($sformatf("bubble_vld_%0d", i), hist[c0+2+i], pat[i]);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
